// File: rtl/uart_rx_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_core                                                  |
// | Purpose  : 8N1 asynchronous serial receiver, LSB first, with internal    |
// |            baud timing. Drives the rx_data/rx_int handshake used by the  |
// |            transmitter, plus rx_valid and frame_err strobes.             |
// | Ports    : clk        - system clock, rising edge                        |
// |            rst        - synchronous reset, active-high                   |
// |            rs232_rx   - asynchronous serial line, idle high              |
// |            rx_data    - last correctly framed byte                       |
// |            rx_int     - high while a validated frame is in progress      |
// |            rx_valid   - one-cycle strobe, rx_data just updated           |
// |            frame_err  - one-cycle strobe, stop bit sampled low           |
// |            parity_err - one-cycle strobe, even parity mismatch           |
// |                         (only with UART_RX_PARITY_EN)                    |
// | Options  : UART_RX_PARITY_EN - 8E1 framing with a parity bit             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_core #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       rx_valid,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd5,
`endif
    S_WAIT_IDLE = 3'd4
  } state_t;

  // Input conditioning: two-stage synchronizer plus a history stage.
  logic       sync1, sync2, sync_prev;
  // warm marks when sync2 carries a real line sample after reset; armed is
  // set once that real sample has been high, so a line held low across
  // reset release never looks like a start edge.
  logic [1:0] warm;
  logic       armed;
  logic       start_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      warm      <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync1     <= rs232_rx;
      sync2     <= sync1;
      sync_prev <= sync2;
      warm      <= {warm[0], 1'b1};
      armed     <= armed | (warm[1] & sync2);
    end
  end

  assign start_edge = armed & sync_prev & ~sync2;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_n;
  logic [3:0]       bit_cnt, bit_n;
  logic [7:0]       shift_reg, shift_n;
  logic [7:0]       data_n;
  logic             int_n, valid_n, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_n;
  logic             perr_n;
  logic             par_bad;
  assign par_bad = ^{shift_reg, par_bit};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= 8'h00;
      rx_int    <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      rx_data   <= data_n;
      rx_int    <= int_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_n;
      parity_err <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    data_n  = rx_data;
    int_n   = rx_int;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_bit;
    perr_n  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          baud_n  = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        // Re-check the line half a bit in; a high sample was a glitch and
        // rx_int is left alone so its falling edge always means a frame.
        if (baud_cnt == HALF_LAST) begin
          if (!sync2) begin
            int_n   = 1'b1;
            baud_n  = '0;
            bit_n   = '0;
            state_n = S_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_cnt == BIT_LAST) begin
          shift_n = {sync2, shift_reg[7:1]};
          bit_n   = bit_cnt + 4'd1;
          baud_n  = '0;
          if (bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_cnt == BIT_LAST) begin
          par_n   = sync2;
          baud_n  = '0;
          state_n = S_STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_cnt == BIT_LAST) begin
          baud_n = '0;
          int_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_n = par_bad;
`endif
          if (sync2) begin
`ifdef UART_RX_PARITY_EN
            if (!par_bad) begin
              data_n  = shift_reg;
              valid_n = 1'b1;
            end
`else
            data_n  = shift_reg;
            valid_n = 1'b1;
`endif
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_WAIT_IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        // Hold off during a break so the low line is not taken as a start.
        if (sync2) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_core                                               |
// | Purpose  : Self-checking bench for uart_rx_core. A frame-level model     |
// |            predicts the strobe kind, byte and cycle of every frame sent; |
// |            a compare process checks the DUT against it every cycle.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx_core;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PEXTRA   = DIV;
`else
  localparam int PEXTRA   = 0;
`endif
  // Line fall -> strobe: 2 synchronizer clocks, 1 to enter START,
  // half a bit to validate the start, then 8 data bits and the stop bit.
  localparam int LAT      = 3 + HALF + 9 * DIV + PEXTRA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rs232_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_int, rx_valid, frame_err;
  logic       parity_err;

  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outcome of one frame: kind 0 = valid, 1 = framing, 2 = parity.
  typedef struct {
    int         f;
    int         exp;
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        q[$];
  logic [7:0] model_data = 8'h00;
  int         n_pass = 0, n_total = 0;
  int         n_valid = 0, n_ferr = 0, n_perr = 0, n_rise = 0;
  int         last_vc = 0, prev_vc = 0, last_rise = 0, last_f = 0;
  logic       run_cmp = 1'b0;
  logic       int_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    else n_pass++;
  endtask

  function automatic logic [2:0] kind_vec(input int k);
    return (k == 0) ? 3'b100 : (k == 1) ? 3'b010 : 3'b001;
  endfunction

  // Per-cycle comparison against the frame model.
  always @(negedge clk) begin
    ev_t h;
    if (run_cmp && !rst) begin
      if (rx_int && !int_q) begin n_rise++; last_rise = cyc; end
      if (rx_valid) begin n_valid++; prev_vc = last_vc; last_vc = cyc; end
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
      if (rx_valid || frame_err || parity_err) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
        end else begin
          h = q.pop_front();
          chk("strobe_kind", {29'd0, rx_valid, frame_err, parity_err}, {29'd0, kind_vec(h.kind)});
          chk("strobe_cycle", (cyc >= h.exp - 1 && cyc <= h.exp + 1) ? h.exp : cyc, h.exp);
          if (h.kind == 0) model_data = h.data;
        end
      end else if (q.size() > 0 && cyc > q[0].exp + 1) begin
        h = q.pop_front();
        chk("strobe_missing", 32'd0, 32'd1);
        if (h.kind == 0) model_data = h.data;
      end
      chk("rx_data", {24'd0, rx_data}, {24'd0, model_data});
      if (q.size() == 0) begin
        chk("rx_int_idle", {31'd0, rx_int}, 32'd0);
      end else if (cyc <= q[0].f + 6) begin
        chk("rx_int_before", {31'd0, rx_int}, 32'd0);
      end else if (cyc >= q[0].f + 4 + HALF && cyc <= q[0].exp - 2) begin
        chk("rx_int_busy", {31'd0, rx_int}, 32'd1);
      end
    end
    int_q = rx_int;
  end

  task automatic drive_bit(input logic b);
    rs232_rx = b;
    repeat (DIV) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    rs232_rx = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int kind);
    ev_t e;
    e.f = cyc; e.exp = cyc + LAT; e.kind = kind; e.data = b;
    last_f = cyc;
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) rs232_rx = 1'b1;
`endif
    drive_bit(stop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
    chk("reset_rx_int", {31'd0, rx_int}, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmp = 1'b1;
    idle(20);

    // Clean 8'hA5
    send_frame(8'hA5, ^8'hA5, 1'b1, 0);
    idle(20);
    chk("a5_rx_data", {24'd0, rx_data}, 32'hA5);
    chk("a5_valid_count", n_valid, 1);
    chk("a5_ferr_count", n_ferr, 0);
    d = last_rise - last_f;
    chk("a5_int_rise", (d >= 7 && d <= 9) ? 32'd1 : d, 32'd1);

    // 3-clock low glitch
    rs232_rx = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    idle(40);
    chk("glitch_rise_count", n_rise, 1);
    chk("glitch_valid_count", n_valid, 1);

    // 8'h3C with stop bit low, then a break
    send_frame(8'h3C, ^8'h3C, 1'b0, 1);
    rs232_rx = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    idle(30);
    chk("ferr_count", n_ferr, 1);
    chk("ferr_rx_data", {24'd0, rx_data}, 32'hA5);
    chk("ferr_rise_count", n_rise, 2);

    // Back-to-back 8'h00 then 8'hFF
    send_frame(8'h00, ^8'h00, 1'b1, 0);
    send_frame(8'hFF, ^8'hFF, 1'b1, 0);
    idle(20);
    chk("b2b_valid_count", n_valid, 3);
    chk("b2b_rx_data", {24'd0, rx_data}, 32'hFF);
    d = last_vc - prev_vc;
    chk("b2b_gap", (d >= 10 * DIV + PEXTRA - 1 && d <= 10 * DIV + PEXTRA + 1) ? 32'd1 : d, 32'd1);

    // Reset during bit 4 of 8'h55; transmitter aborts
    begin
      ev_t e;
      e.f = cyc; e.exp = cyc + LAT; e.kind = 0; e.data = 8'h55;
      q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i));
      rs232_rx = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      q.delete();
      model_data = 8'h00;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    @(negedge clk);
    chk("midrst_rx_data", {24'd0, rx_data}, 32'h00);
    chk("midrst_rx_int", {31'd0, rx_int}, 32'd0);
    @(posedge clk); #1;
    idle(100);
    chk("midrst_valid_count", n_valid, 3);
    chk("midrst_ferr_count", n_ferr, 1);
    send_frame(8'h81, ^8'h81, 1'b1, 0);
    idle(20);
    chk("post_rst_rx_data", {24'd0, rx_data}, 32'h81);
    chk("post_rst_valid_count", n_valid, 4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(20);
    chk("par_ok_rx_data", {24'd0, rx_data}, 32'h07);
    send_frame(8'h07, 1'b0, 1'b1, 2);
    idle(20);
    chk("par_bad_count", n_perr, 1);
    chk("par_bad_valid_count", n_valid, 5);
    chk("par_bad_rx_data", {24'd0, rx_data}, 32'h07);
`endif

    chk("all_frames_seen", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
